// File: rtl/lbp_pkg.sv
// lbp_pkg: constants and helpers shared by the LBP interpolation pipeline.
//   - bilinear weight LUT for sampling radius 0..3 (8 fractional bits, each
//     set sums to 256)
//   - sample/lane bookkeeping: 8 samples counter-clockwise from 0 degrees,
//     on-axis samples on even lanes, diagonal samples on odd lanes
package lbp_pkg;

  localparam int unsigned WGT_W       = 8;    // fractional bits of a weight
  localparam int unsigned NUM_SAMPLES = 8;
  localparam int unsigned NUM_AXIS    = 4;
  localparam int unsigned NUM_DIAG    = 4;
  localparam int unsigned NUM_TAPS    = 4;    // pixels per diagonal neighbourhood
  localparam int unsigned ROUND_BIAS  = 128;  // half an LSB after the >> WGT_W

  // Output lane of each sample, counter-clockwise from 0 degrees.
  localparam int unsigned LANE_0   = 0;
  localparam int unsigned LANE_45  = 1;
  localparam int unsigned LANE_90  = 2;
  localparam int unsigned LANE_135 = 3;
  localparam int unsigned LANE_180 = 4;
  localparam int unsigned LANE_225 = 5;
  localparam int unsigned LANE_270 = 6;
  localparam int unsigned LANE_315 = 7;

  localparam int unsigned AXIS_LANE [NUM_AXIS] = '{LANE_0, LANE_90, LANE_180, LANE_270};
  localparam int unsigned DIAG_LANE [NUM_DIAG] = '{LANE_45, LANE_135, LANE_225, LANE_315};

  // One extra integer bit so that a weight of exactly 1.0 (256) is representable.
  typedef logic [WGT_W:0] wgt_t;
  // Index 0 is w1 (nearest corner) .. index 3 is w4 (far corner).
  typedef wgt_t [NUM_TAPS-1:0] wgt_set_t;

  localparam wgt_set_t WGT_R0 = {9'd0,   9'd0,  9'd0,  9'd256};
  localparam wgt_set_t WGT_R1 = {9'd128, 9'd53, 9'd53, 9'd22};
  localparam wgt_set_t WGT_R2 = {9'd44,  9'd62, 9'd62, 9'd88};
  localparam wgt_set_t WGT_R3 = {9'd4,   9'd27, 9'd27, 9'd198};

  function automatic wgt_set_t lut_weights(input logic [1:0] radius);
    wgt_set_t w;
    case (radius)
      2'd0:    w = WGT_R0;
      2'd1:    w = WGT_R1;
      2'd2:    w = WGT_R2;
      default: w = WGT_R3;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lbp_bilerp.sv
// lbp_bilerp: weighted sum of one 4-pixel diagonal neighbourhood.
//   stage 2: four products (DATA_W+9 bits each), captured when en_mul
//   stage 3: sum (DATA_W+11 bits), optional rounding, >> 8, clamp to
//            2^DATA_W-1, captured when en_sum
// Ports: clk, rst (sync, active-high), en_mul/en_sum (stage valids feeding
//   each register), pix (4 pixels, k=1 in the low lane), wgt (w1..w4),
//   res (interpolated sample, registered).
// Config: define INTERP_ROUND_EN to add half an LSB before the shift
//   (round half up); otherwise the shift truncates.
module lbp_bilerp
  import lbp_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_mul,
  input  logic                         en_sum,
  input  logic [NUM_TAPS*DATA_W-1:0]   pix,
  input  wgt_set_t                     wgt,
  output logic [DATA_W-1:0]            res
);

  localparam int unsigned PROD_W = DATA_W + WGT_W + 1;
  localparam int unsigned ACC_W  = DATA_W + WGT_W + 3;

  logic [PROD_W-1:0] prod [NUM_TAPS];
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  shifted;
  logic [DATA_W-1:0] res_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_TAPS; i++) prod[i] <= '0;
    end else if (en_mul) begin
      for (int unsigned i = 0; i < NUM_TAPS; i++)
        prod[i] <= PROD_W'(wgt[i]) * PROD_W'(pix[i*DATA_W +: DATA_W]);
    end
  end

  always_comb begin
    acc = '0;
    for (int unsigned i = 0; i < NUM_TAPS; i++) acc = acc + ACC_W'(prod[i]);
`ifdef INTERP_ROUND_EN
    acc = acc + ACC_W'(ROUND_BIAS);
`endif
    shifted = acc >> WGT_W;
    if (|shifted[ACC_W-1:DATA_W]) res_c = '1;
    else                          res_c = shifted[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst)         res <= '0;
    else if (en_sum) res <= res_c;
  end

endmodule

// File: rtl/lbp_interp_pipe.sv
// lbp_interp_pipe: produces the 8 circular LBP samples for one pixel.
//   On-axis samples pass through; the four diagonal samples are bilinearly
//   interpolated from their 2x2 neighbourhoods with weights chosen by r.
//   Latency 3+OUT_REG cycles, one sample set per cycle, no stall.
// Ports:
//   clk, rst      - rising-edge clock, synchronous active-high reset
//   done_i        - sample set valid; r, S_axis_i, S_diag_i qualified by it
//   r             - sampling radius 0..3
//   S_axis_i      - 4 on-axis samples (0, 90, 180, 270 degrees)
//   S_diag_i      - 4 neighbourhoods (45, 135, 225, 315 degrees), 4 pixels
//                   each, pixel k=1 in the lowest lane of its neighbourhood
//   S_o, done_o   - 8 samples (lane j = S(j+1)) and their valid
// Config: INTERP_ROUND_EN selects round-half-up instead of truncation.
module lbp_interp_pipe
  import lbp_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned OUT_REG = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                done_i,
  input  logic [1:0]                          r,
  input  logic [NUM_AXIS*DATA_W-1:0]          S_axis_i,
  input  logic [NUM_DIAG*NUM_TAPS*DATA_W-1:0] S_diag_i,
  output logic [NUM_SAMPLES*DATA_W-1:0]       S_o,
  output logic                                done_o
);

  localparam int unsigned NB_W = NUM_TAPS * DATA_W;

  // Stage 1: inputs plus the weights for this set's radius.
  logic                                v1;
  wgt_set_t                            wgt1;
  logic [NUM_AXIS*DATA_W-1:0]          axis1;
  logic [NUM_DIAG*NB_W-1:0]            diag1;
  // Stages 2..3: axis samples delayed to meet the diagonal results.
  logic                                v2, v3;
  logic [NUM_AXIS*DATA_W-1:0]          axis2, axis3;
  logic [DATA_W-1:0]                   diag3 [NUM_DIAG];
  logic [NUM_SAMPLES*DATA_W-1:0]       s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      wgt1  <= '0;
      axis1 <= '0;
      diag1 <= '0;
    end else begin
      v1 <= done_i;
      if (done_i) begin
        wgt1  <= lut_weights(r);
        axis1 <= S_axis_i;
        diag1 <= S_diag_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2    <= 1'b0;
      v3    <= 1'b0;
      axis2 <= '0;
      axis3 <= '0;
    end else begin
      v2 <= v1;
      v3 <= v2;
      if (v1) axis2 <= axis1;
      if (v2) axis3 <= axis2;
    end
  end

  for (genvar d = 0; d < NUM_DIAG; d++) begin : g_diag
    lbp_bilerp #(.DATA_W(DATA_W)) u_bilerp (
      .clk    (clk),
      .rst    (rst),
      .en_mul (v1),
      .en_sum (v2),
      .pix    (diag1[d*NB_W +: NB_W]),
      .wgt    (wgt1),
      .res    (diag3[d])
    );
  end

  // Interleave axis and diagonal samples into counter-clockwise lane order.
  always_comb begin
    s3 = '0;
    for (int unsigned i = 0; i < NUM_AXIS; i++)
      s3[AXIS_LANE[i]*DATA_W +: DATA_W] = axis3[i*DATA_W +: DATA_W];
    for (int unsigned i = 0; i < NUM_DIAG; i++)
      s3[DIAG_LANE[i]*DATA_W +: DATA_W] = diag3[i];
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                          v4;
    logic [NUM_SAMPLES*DATA_W-1:0] s4;

    always_ff @(posedge clk) begin
      if (rst) begin
        v4 <= 1'b0;
        s4 <= '0;
      end else begin
        v4 <= v3;
        if (v3) s4 <= s3;
      end
    end

    assign S_o    = s4;
    assign done_o = v4;
  end else begin : g_no_out_reg
    assign S_o    = s3;
    assign done_o = v3;
  end

endmodule
